// File: rtl/hls_pp_loop_status_monitor.sv
// hls_pp_loop_status_monitor
//   Passive activity monitor for one HLS block with one pipelined loop. It watches the block's
//   ap_* handshake and the loop FSM state vector. It keeps saturating counters of invocations,
//   latency, iterations, stalls and loop cycles. It never drives the kernel.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ap_start/ready/done/continue   block handshake being observed
//   finish                end of run; freezes all state until reset
//   cur_state             loop FSM current state (one-hot)
//   pre_loop_state0, post_loop_state0/1 (+valid)   states bracketing the loop
//   iter_start/end_state, loop_quit_state          loop states
//   iter_start/end_enable/block   pipeline enable and block qualifiers
//   quit_at_end           trip count source: 1 = iterations ended, 0 = iterations started
//   mod_* outputs         handshake counts and start-to-done latency
//   loop_* / iter_* / last_trip_cnt   loop statistics
//   frozen, err_flag      finish seen; sticky protocol violation
module hls_pp_loop_status_monitor #(
   parameter int unsigned STATE_W = 5,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ap_start,
   input  logic               ap_ready,
   input  logic               ap_done,
   input  logic               ap_continue,
   input  logic               finish,
   input  logic [STATE_W-1:0] cur_state,
   input  logic [STATE_W-1:0] pre_loop_state0,
   input  logic               pre_states_valid,
   input  logic [STATE_W-1:0] post_loop_state0,
   input  logic [STATE_W-1:0] post_loop_state1,
   input  logic [1:0]         post_states_valid,
   input  logic [STATE_W-1:0] iter_start_state,
   input  logic [STATE_W-1:0] iter_end_state,
   input  logic [STATE_W-1:0] loop_quit_state,
   input  logic               iter_start_enable,
   input  logic               iter_start_block,
   input  logic               iter_end_enable,
   input  logic               iter_end_block,
   input  logic               quit_at_end,
   output logic               mod_busy,
   output logic [CNT_W-1:0]   mod_start_cnt,
   output logic [CNT_W-1:0]   mod_done_cnt,
   output logic [CNT_W-1:0]   mod_ready_cnt,
   output logic [CNT_W-1:0]   mod_last_lat,
   output logic [CNT_W-1:0]   mod_max_lat,
   output logic               loop_active,
   output logic [CNT_W-1:0]   loop_inv_cnt,
   output logic [CNT_W-1:0]   iter_start_cnt,
   output logic [CNT_W-1:0]   iter_end_cnt,
   output logic [CNT_W-1:0]   loop_stall_cnt,
   output logic [CNT_W-1:0]   loop_cycle_cnt,
   output logic [CNT_W-1:0]   last_trip_cnt,
   output logic               frozen,
   output logic               err_flag
);

   localparam logic [1:0] MOD_IDLE      = 2'd0;
   localparam logic [1:0] MOD_RUN       = 2'd1;
   localparam logic [1:0] MOD_WAIT_CONT = 2'd2;
   localparam logic [0:0] L_IDLE        = 1'b0;
   localparam logic [0:0] L_ACTIVE      = 1'b1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      sat_inc = (en && !(&v)) ? v + CNT_ONE : v;
   endfunction

   logic [1:0]         mod_state_q, mod_state_d;
   logic [0:0]         loop_state_q, loop_state_d;
   logic [STATE_W-1:0] prev_state_q, prev_state_d;
   logic [CNT_W-1:0]   lat_acc_q, lat_acc_d;
   logic [CNT_W-1:0]   start_cnt_q, start_cnt_d, done_cnt_q, done_cnt_d;
   logic [CNT_W-1:0]   ready_cnt_q, ready_cnt_d, last_lat_q, last_lat_d, max_lat_q, max_lat_d;
   logic [CNT_W-1:0]   inv_cnt_q, inv_cnt_d, is_cnt_q, is_cnt_d, ie_cnt_q, ie_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d, cycle_cnt_q, cycle_cnt_d, trip_q, trip_d;
   logic [CNT_W-1:0]   starts_inv_q, starts_inv_d, ends_inv_q, ends_inv_d;
   logic               frozen_q, err_q, err_d;

   logic               lat_rec;
   logic [CNT_W-1:0]   lat_val;
   logic               start_ev, end_ev, stall, entry, exit_hit, post_hit;
   logic [CNT_W-1:0]   starts_nxt, ends_nxt;

   always_comb begin
      mod_state_d  = mod_state_q;
      lat_acc_d    = lat_acc_q;
      start_cnt_d  = start_cnt_q;
      done_cnt_d   = done_cnt_q;
      ready_cnt_d  = sat_inc(ready_cnt_q, ap_ready);
      err_d        = err_q;
      lat_rec      = 1'b0;
      lat_val      = CNT_ZERO;
      unique case (mod_state_q)
         MOD_IDLE: begin
            if (ap_start) begin
               start_cnt_d = sat_inc(start_cnt_q, 1'b1);
               if (ap_done) begin
                  // Zero-latency call: finished in its own start cycle.
                  done_cnt_d = sat_inc(done_cnt_q, 1'b1);
                  lat_rec    = 1'b1;
                  lat_val    = CNT_ONE;
               end else begin
                  lat_acc_d   = CNT_ONE;
                  mod_state_d = MOD_RUN;
               end
            end else if (ap_done) begin
               err_d = 1'b1;
            end
         end
         MOD_RUN: begin
            lat_acc_d = sat_inc(lat_acc_q, 1'b1);
            if (ap_done) begin
               // Latency includes the done cycle itself.
               done_cnt_d = sat_inc(done_cnt_q, 1'b1);
               lat_rec    = 1'b1;
               lat_val    = lat_acc_d;
               if (!ap_continue) begin
                  mod_state_d = MOD_WAIT_CONT;
               end else if (ap_start) begin
                  start_cnt_d = sat_inc(start_cnt_q, 1'b1);
                  lat_acc_d   = CNT_ONE;
               end else begin
                  mod_state_d = MOD_IDLE;
               end
            end
         end
         MOD_WAIT_CONT: begin
            if (ap_continue) mod_state_d = MOD_IDLE;
         end
         default: mod_state_d = MOD_IDLE;
      endcase
      last_lat_d = lat_rec ? lat_val : last_lat_q;
      max_lat_d  = (lat_rec && (lat_val > max_lat_q)) ? lat_val : max_lat_q;
   end

   always_comb begin
      prev_state_d = cur_state;
      start_ev = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
      end_ev   = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
      stall    = (loop_state_q == L_ACTIVE) &
                 ((iter_start_block & iter_start_enable) | (iter_end_block & iter_end_enable));
      post_hit = (post_states_valid[0] & (cur_state == post_loop_state0)) |
                 (post_states_valid[1] & (cur_state == post_loop_state1));
      entry    = pre_states_valid & (prev_state_q == pre_loop_state0) &
                 (cur_state == iter_start_state);
      exit_hit = (loop_state_q == L_ACTIVE) & (prev_state_q == loop_quit_state) & post_hit;

      is_cnt_d    = sat_inc(is_cnt_q, start_ev);
      ie_cnt_d    = sat_inc(ie_cnt_q, end_ev);
      stall_cnt_d = sat_inc(stall_cnt_q, stall);
      cycle_cnt_d = sat_inc(cycle_cnt_q, loop_state_q == L_ACTIVE);
      starts_nxt  = sat_inc(starts_inv_q, start_ev);
      ends_nxt    = sat_inc(ends_inv_q, end_ev);

      loop_state_d = loop_state_q;
      inv_cnt_d    = inv_cnt_q;
      trip_d       = trip_q;
      starts_inv_d = starts_nxt;
      ends_inv_d   = ends_nxt;
      // Exit is resolved before entry so a same-cycle exit/re-entry starts a fresh invocation.
      if (exit_hit) begin
         trip_d       = quit_at_end ? ends_nxt : starts_nxt;
         loop_state_d = L_IDLE;
      end
      if ((loop_state_d == L_IDLE) && entry) begin
         loop_state_d = L_ACTIVE;
         inv_cnt_d    = sat_inc(inv_cnt_q, 1'b1);
         starts_inv_d = start_ev ? CNT_ONE : CNT_ZERO;
         ends_inv_d   = end_ev ? CNT_ONE : CNT_ZERO;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mod_state_q  <= MOD_IDLE;
         loop_state_q <= L_IDLE;
         prev_state_q <= '0;
         lat_acc_q    <= '0;
         start_cnt_q  <= '0;
         done_cnt_q   <= '0;
         ready_cnt_q  <= '0;
         last_lat_q   <= '0;
         max_lat_q    <= '0;
         inv_cnt_q    <= '0;
         is_cnt_q     <= '0;
         ie_cnt_q     <= '0;
         stall_cnt_q  <= '0;
         cycle_cnt_q  <= '0;
         trip_q       <= '0;
         starts_inv_q <= '0;
         ends_inv_q   <= '0;
         frozen_q     <= 1'b0;
         err_q        <= 1'b0;
      end else if (!frozen_q) begin
         mod_state_q  <= mod_state_d;
         loop_state_q <= loop_state_d;
         prev_state_q <= prev_state_d;
         lat_acc_q    <= lat_acc_d;
         start_cnt_q  <= start_cnt_d;
         done_cnt_q   <= done_cnt_d;
         ready_cnt_q  <= ready_cnt_d;
         last_lat_q   <= last_lat_d;
         max_lat_q    <= max_lat_d;
         inv_cnt_q    <= inv_cnt_d;
         is_cnt_q     <= is_cnt_d;
         ie_cnt_q     <= ie_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
         cycle_cnt_q  <= cycle_cnt_d;
         trip_q       <= trip_d;
         starts_inv_q <= starts_inv_d;
         ends_inv_q   <= ends_inv_d;
         frozen_q     <= finish;
         err_q        <= err_d | (ie_cnt_d > is_cnt_d);
      end
   end

   assign mod_busy       = (mod_state_q != MOD_IDLE);
   assign mod_start_cnt  = start_cnt_q;
   assign mod_done_cnt   = done_cnt_q;
   assign mod_ready_cnt  = ready_cnt_q;
   assign mod_last_lat   = last_lat_q;
   assign mod_max_lat    = max_lat_q;
   assign loop_active    = (loop_state_q == L_ACTIVE);
   assign loop_inv_cnt   = inv_cnt_q;
   assign iter_start_cnt = is_cnt_q;
   assign iter_end_cnt   = ie_cnt_q;
   assign loop_stall_cnt = stall_cnt_q;
   assign loop_cycle_cnt = cycle_cnt_q;
   assign last_trip_cnt  = trip_q;
   assign frozen         = frozen_q;
   assign err_flag       = err_q;

endmodule

// File: tb/tb_hls_pp_loop_status_monitor.sv
// Directed bench for hls_pp_loop_status_monitor: a per-cycle vector table for the handshake and
// loop flows, followed by hand-written freeze, protocol-error and reset sequences.
module tb_hls_pp_loop_status_monitor;

   logic        clock = 1'b0;
   logic        reset;
   logic        ap_start, ap_ready, ap_done, ap_continue, finish;
   logic [4:0]  cur_state, pre_loop_state0, post_loop_state0, post_loop_state1;
   logic [4:0]  iter_start_state, iter_end_state, loop_quit_state;
   logic        pre_states_valid;
   logic [1:0]  post_states_valid;
   logic        iter_start_enable, iter_start_block, iter_end_enable, iter_end_block;
   logic        quit_at_end;
   logic        mod_busy, loop_active, frozen, err_flag;
   logic [31:0] mod_start_cnt, mod_done_cnt, mod_ready_cnt, mod_last_lat, mod_max_lat;
   logic [31:0] loop_inv_cnt, iter_start_cnt, iter_end_cnt, loop_stall_cnt, loop_cycle_cnt;
   logic [31:0] last_trip_cnt;

   int n_cmp = 0;
   int n_err = 0;

   hls_pp_loop_status_monitor #(.STATE_W(5), .CNT_W(32)) dut (
      .clock(clock), .reset(reset),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
      .finish(finish), .cur_state(cur_state),
      .pre_loop_state0(pre_loop_state0), .pre_states_valid(pre_states_valid),
      .post_loop_state0(post_loop_state0), .post_loop_state1(post_loop_state1),
      .post_states_valid(post_states_valid),
      .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
      .loop_quit_state(loop_quit_state),
      .iter_start_enable(iter_start_enable), .iter_start_block(iter_start_block),
      .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
      .quit_at_end(quit_at_end),
      .mod_busy(mod_busy), .mod_start_cnt(mod_start_cnt), .mod_done_cnt(mod_done_cnt),
      .mod_ready_cnt(mod_ready_cnt), .mod_last_lat(mod_last_lat), .mod_max_lat(mod_max_lat),
      .loop_active(loop_active), .loop_inv_cnt(loop_inv_cnt),
      .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
      .loop_stall_cnt(loop_stall_cnt), .loop_cycle_cnt(loop_cycle_cnt),
      .last_trip_cnt(last_trip_cnt), .frozen(frozen), .err_flag(err_flag)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic        st, rd, dn, ct;
      logic [4:0]  cur;
      logic        sen, sbl, een, ebl, qae;
      logic        e_busy, e_act, e_err;
      logic [31:0] e_scnt, e_dcnt, e_llat, e_is, e_ie, e_trip, e_inv;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, input logic rd, input logic dn, input logic ct,
                      input logic [4:0] cur, input logic sen, input logic sbl,
                      input logic een, input logic ebl, input logic qae,
                      input logic eb, input logic ea, input logic ee,
                      input int es, input int ed, input int el, input int eis,
                      input int eie, input int etr, input int einv);
      vec_t v;
      v.st = st; v.rd = rd; v.dn = dn; v.ct = ct; v.cur = cur;
      v.sen = sen; v.sbl = sbl; v.een = een; v.ebl = ebl; v.qae = qae;
      v.e_busy = eb; v.e_act = ea; v.e_err = ee;
      v.e_scnt = es; v.e_dcnt = ed; v.e_llat = el; v.e_is = eis; v.e_ie = eie;
      v.e_trip = etr; v.e_inv = einv;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
      cur_state = 5'b00000;
      iter_start_enable = 0; iter_start_block = 0; iter_end_enable = 0; iter_end_block = 0;
      quit_at_end = 1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"}, 32'(mod_busy), 0);
      chk({tag, " start_cnt"}, mod_start_cnt, 0);
      chk({tag, " done_cnt"}, mod_done_cnt, 0);
      chk({tag, " ready_cnt"}, mod_ready_cnt, 0);
      chk({tag, " last_lat"}, mod_last_lat, 0);
      chk({tag, " max_lat"}, mod_max_lat, 0);
      chk({tag, " loop_active"}, 32'(loop_active), 0);
      chk({tag, " inv_cnt"}, loop_inv_cnt, 0);
      chk({tag, " iter_start"}, iter_start_cnt, 0);
      chk({tag, " iter_end"}, iter_end_cnt, 0);
      chk({tag, " stall_cnt"}, loop_stall_cnt, 0);
      chk({tag, " cycle_cnt"}, loop_cycle_cnt, 0);
      chk({tag, " trip"}, last_trip_cnt, 0);
      chk({tag, " frozen"}, 32'(frozen), 0);
      chk({tag, " err"}, 32'(err_flag), 0);
   endtask

   initial begin
      pre_loop_state0   = 5'b00001;
      pre_states_valid  = 1;
      iter_start_state  = 5'b00010;
      iter_end_state    = 5'b00010;
      loop_quit_state   = 5'b00010;
      post_loop_state0  = 5'b00100;
      post_loop_state1  = 5'b01000;
      post_states_valid = 2'b01;
      idle_inputs();
      reset = 1;

      //   st rd dn ct cur       sen sbl een ebl qae  busy act err  scnt dcnt llat is ie trip inv
      // Handshake: start, done 4 cycles later -> latency 5
      add(1, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 0,  1, 0, 0,  0, 0, 0, 0);
      add(0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 0,  1, 0, 0,  0, 0, 0, 0);
      add(0, 1, 0, 1, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 0,  1, 0, 0,  0, 0, 0, 0);
      add(0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 0,  1, 0, 0,  0, 0, 0, 0);
      add(0, 0, 1, 1, 5'b00000, 0, 0, 0, 0, 1,  0, 0, 0,  1, 1, 5,  0, 0, 0, 0);
      // Back-to-back: done+start restart, each call 3 cycles inclusive
      add(1, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 0,  2, 1, 5,  0, 0, 0, 0);
      add(0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 0,  2, 1, 5,  0, 0, 0, 0);
      add(1, 0, 1, 1, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 0,  3, 2, 3,  0, 0, 0, 0);
      add(0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 0,  3, 2, 3,  0, 0, 0, 0);
      add(0, 0, 1, 1, 5'b00000, 0, 0, 0, 0, 1,  0, 0, 0,  3, 3, 3,  0, 0, 0, 0);
      // Done with ap_continue low waits; start while waiting is ignored
      add(1, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 0,  4, 3, 3,  0, 0, 0, 0);
      add(0, 0, 1, 0, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 0,  4, 4, 2,  0, 0, 0, 0);
      add(1, 1, 0, 0, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 0,  4, 4, 2,  0, 0, 0, 0);
      add(0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 1,  0, 0, 0,  4, 4, 2,  0, 0, 0, 0);
      // Start and done together in IDLE: latency 1, no error
      add(1, 0, 1, 1, 5'b00000, 0, 0, 0, 0, 1,  0, 0, 0,  5, 5, 1,  0, 0, 0, 0);
      // Loop of 4 iterations, end enable one cycle behind start, trip = ends
      add(0, 0, 0, 1, 5'b00001, 0, 0, 0, 0, 1,  0, 0, 0,  5, 5, 1,  0, 0, 0, 0);
      add(0, 0, 0, 1, 5'b00010, 1, 0, 0, 0, 1,  0, 1, 0,  5, 5, 1,  1, 0, 0, 1);
      add(0, 0, 0, 1, 5'b00010, 1, 0, 1, 0, 1,  0, 1, 0,  5, 5, 1,  2, 1, 0, 1);
      add(0, 0, 0, 1, 5'b00010, 1, 0, 1, 0, 1,  0, 1, 0,  5, 5, 1,  3, 2, 0, 1);
      add(0, 0, 0, 1, 5'b00010, 1, 0, 1, 0, 1,  0, 1, 0,  5, 5, 1,  4, 3, 0, 1);
      add(0, 0, 0, 1, 5'b00010, 0, 0, 1, 0, 1,  0, 1, 0,  5, 5, 1,  4, 4, 0, 1);
      add(0, 0, 0, 1, 5'b00100, 0, 0, 0, 0, 1,  0, 0, 0,  5, 5, 1,  4, 4, 4, 1);
      // Second loop with two blocked start cycles; invalid post1 does not exit; trip = starts
      add(0, 0, 0, 1, 5'b00001, 0, 0, 0, 0, 1,  0, 0, 0,  5, 5, 1,  4, 4, 4, 1);
      add(0, 0, 0, 1, 5'b00010, 1, 0, 0, 0, 1,  0, 1, 0,  5, 5, 1,  5, 4, 4, 2);
      add(0, 0, 0, 1, 5'b00010, 1, 1, 1, 0, 1,  0, 1, 0,  5, 5, 1,  5, 5, 4, 2);
      add(0, 0, 0, 1, 5'b00010, 1, 1, 0, 0, 1,  0, 1, 0,  5, 5, 1,  5, 5, 4, 2);
      add(0, 0, 0, 1, 5'b00010, 1, 0, 1, 0, 1,  0, 1, 0,  5, 5, 1,  6, 6, 4, 2);
      add(0, 0, 0, 1, 5'b00010, 1, 0, 0, 0, 1,  0, 1, 0,  5, 5, 1,  7, 6, 4, 2);
      add(0, 0, 0, 1, 5'b01000, 0, 0, 0, 0, 1,  0, 1, 0,  5, 5, 1,  7, 6, 4, 2);
      add(0, 0, 0, 1, 5'b00010, 0, 0, 0, 0, 1,  0, 1, 0,  5, 5, 1,  7, 6, 4, 2);
      add(0, 0, 0, 1, 5'b00100, 0, 0, 0, 0, 0,  0, 0, 0,  5, 5, 1,  7, 6, 3, 2);

      repeat (2) @(posedge clock);
      #1;
      chk_all_zero("reset");
      reset = 0;

      for (int i = 0; i < vecs.size(); i++) begin
         ap_start = vecs[i].st; ap_ready = vecs[i].rd; ap_done = vecs[i].dn;
         ap_continue = vecs[i].ct; cur_state = vecs[i].cur;
         iter_start_enable = vecs[i].sen; iter_start_block = vecs[i].sbl;
         iter_end_enable = vecs[i].een; iter_end_block = vecs[i].ebl;
         quit_at_end = vecs[i].qae;
         tick();
         chk($sformatf("row%0d busy", i), 32'(mod_busy), 32'(vecs[i].e_busy));
         chk($sformatf("row%0d loop_active", i), 32'(loop_active), 32'(vecs[i].e_act));
         chk($sformatf("row%0d err", i), 32'(err_flag), 32'(vecs[i].e_err));
         chk($sformatf("row%0d start_cnt", i), mod_start_cnt, vecs[i].e_scnt);
         chk($sformatf("row%0d done_cnt", i), mod_done_cnt, vecs[i].e_dcnt);
         chk($sformatf("row%0d last_lat", i), mod_last_lat, vecs[i].e_llat);
         chk($sformatf("row%0d iter_start", i), iter_start_cnt, vecs[i].e_is);
         chk($sformatf("row%0d iter_end", i), iter_end_cnt, vecs[i].e_ie);
         chk($sformatf("row%0d trip", i), last_trip_cnt, vecs[i].e_trip);
         chk($sformatf("row%0d inv_cnt", i), loop_inv_cnt, vecs[i].e_inv);
      end
      idle_inputs();

      chk("table ready_cnt", mod_ready_cnt, 2);
      chk("table max_lat", mod_max_lat, 5);
      chk("table cycle_cnt", loop_cycle_cnt, 12);
      chk("table stall_cnt", loop_stall_cnt, 2);
      chk("table frozen", 32'(frozen), 0);

      // Freeze mid-loop: events in the finish cycle count, nothing afterwards
      cur_state = 5'b00001; tick();
      cur_state = 5'b00010; iter_start_enable = 1; tick();
      finish = 1; tick();
      chk("freeze frozen", 32'(frozen), 1);
      chk("freeze iter_start", iter_start_cnt, 9);
      finish = 0; iter_end_enable = 1; ap_start = 1; ap_ready = 1; tick();
      ap_start = 0; ap_done = 1; tick();
      ap_done = 0; iter_start_enable = 0; iter_end_enable = 0; cur_state = 5'b00100; tick();
      tick();
      chk("frozen frozen", 32'(frozen), 1);
      chk("frozen iter_start", iter_start_cnt, 9);
      chk("frozen iter_end", iter_end_cnt, 6);
      chk("frozen inv_cnt", loop_inv_cnt, 3);
      chk("frozen loop_active", 32'(loop_active), 1);
      chk("frozen cycle_cnt", loop_cycle_cnt, 13);
      chk("frozen start_cnt", mod_start_cnt, 5);
      chk("frozen done_cnt", mod_done_cnt, 5);
      chk("frozen ready_cnt", mod_ready_cnt, 2);
      chk("frozen busy", 32'(mod_busy), 0);
      chk("frozen trip", last_trip_cnt, 3);
      idle_inputs();
      do_reset();
      chk_all_zero("post-freeze reset");

      // ap_done in IDLE without ap_start: sticky error, not counted as a done
      ap_done = 1; tick();
      ap_done = 0;
      chk("proto err", 32'(err_flag), 1);
      chk("proto done_cnt", mod_done_cnt, 0);
      ap_start = 1; tick();
      ap_start = 0; ap_done = 1; tick();
      ap_done = 0; tick();
      chk("proto err sticky", 32'(err_flag), 1);
      chk("proto done_cnt after call", mod_done_cnt, 1);
      chk("proto last_lat", mod_last_lat, 2);
      do_reset();
      chk("proto err cleared", 32'(err_flag), 0);

      // More iterations ended than started flags an error
      cur_state = 5'b00010; iter_end_enable = 1; tick();
      idle_inputs();
      chk("iter err", 32'(err_flag), 1);
      chk("iter end_cnt", iter_end_cnt, 1);
      chk("iter loop_active", 32'(loop_active), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
